dbg_trace_buffer: RTL and testbench
===================================

Name: dbg_trace_buffer

Overview:
Retirement trace recorder downstream of the pipeline debugger. It consumes the writeback-stage observation signals (valid, stall, EIP, micro-PC, result) and records every retired micro-op into a circular buffer. The buffer freezes on an EIP-match trigger after a programmable post-trigger count, or on a manual stop. The frozen history is then drained, oldest first, over a valid/ready port.

Parameters:
DEPTH, 16, number of trace entries; power of two, at least 4.
AW, $clog2(DEPTH), pointer width; derived, not overridable.
TS_W, 16, timestamp counter width.

Ports:
CLK  in  1  clock; all state changes on posedge.
RST  in  1  synchronous, active-high reset.
wb_v  in  1  writeback stage holds a valid micro-op.
wb_stall  in  1  writeback stall; no retirement while high.
wb_eip  in  32  EIP of the retiring micro-op.
wb_upc  in  8  micro-PC of the retiring micro-op.
wb_result  in  64  writeback result.
wb_mem_wt  in  1  retiring micro-op writes memory.
wb_mem_wt_addr  in  32  memory write address.
wb_mem_wt_data  in  64  memory write data.
arm  in  1  one-cycle pulse; clears the buffer and starts recording.
stop  in  1  one-cycle pulse; manual freeze.
trig_en  in  1  enables the EIP-match trigger.
trig_eip  in  32  trigger EIP.
post_cnt  in  AW+1  captures taken after the trigger entry; sampled when the trigger fires.
drain  in  1  one-cycle pulse; starts readout. Honoured only in FROZEN.
rd_valid  out  1  rd_data holds a valid entry.
rd_ready  in  1  consumer accepts the entry.
rd_data  out  ENTRY_W  {ts[TS_W-1:0], upc[7:0], eip[31:0], result[63:0]}; with the feature, the {wt, wt_addr, wt_data} fields are also appended.
rd_last  out  1  marks the final entry of the drain.
state  out  3  current FSM state encoding.
count  out  AW+1  number of valid entries held.
triggered  out  1  the trigger fired in the current session (sticky until the next arm).

Behaviour:
- Reset: state=IDLE; count=0; write pointer=0; rd_valid=0; rd_last=0; triggered=0; rd_data=0; ts=0.
- Timestamp counter: free-running TS_W-bit counter that wraps; increments every cycle outside reset.
- Capture: cap = wb_v & ~wb_stall & (state==ARMED | state==POST).
  - The entry is written at the write pointer, with the ts value of that cycle.
  - The pointer then increments modulo DEPTH.
  - count saturates at DEPTH. When count==DEPTH, the oldest entry is overwritten.
  - The oldest entry is always at (wptr - count) mod DEPTH.
- States:
  - IDLE: arm -> ARMED, with count=0 and triggered=0.
  - ARMED:
    - cap & trig_en & wb_eip==trig_eip -> the matching entry is captured and triggered=1.
    - If post_cnt==0 -> FROZEN; otherwise load remaining=post_cnt and go to POST.
  - POST: each cap decrements remaining. The capture that brings remaining to 0 -> FROZEN. Trigger matches are ignored.
  - FROZEN: no captures. drain with count>0 -> DRAIN. drain with count==0 stays FROZEN. arm -> ARMED, with a clear.
  - DRAIN:
    - rd_valid asserts on the cycle after entry, carrying the oldest entry. rd_data is registered.
    - A beat completes on rd_valid & rd_ready: count decrements and the next entry appears the following cycle. rd_valid must never drop without a beat completing.
    - rd_last = rd_valid & (count==1).
    - After the last beat: rd_valid=0 and state -> IDLE.
- Simultaneous events:
  - stop in ARMED/POST -> FROZEN. A capture in the same cycle is still recorded.
  - stop beats trigger in the same cycle: the entry is recorded, triggered=1, and state goes to FROZEN.
  - arm in ARMED/POST restarts the session, clearing count; a capture in that cycle is dropped.
  - arm, stop and drain are all ignored during DRAIN.
  - arm and stop asserted together: arm wins.
  - RST asserted mid-drain: rd_valid drops next cycle and all state returns to reset values.

Optional Feature:
DBG_TRACE_MEMWT_EN.
- Defined: each entry also stores wb_mem_wt, wb_mem_wt_addr and wb_mem_wt_data; ENTRY_W=217.
- Undefined: those inputs are unused; ENTRY_W=120. Behaviour is otherwise identical.

Decomposition:
- Package dbg_trace_pkg holds:
  - state enum: IDLE=0, ARMED=1, POST=2, FROZEN=3, DRAIN=4;
  - entry field offsets and ENTRY_W, under the feature macro;
  - UPC_W=8.
- One sub-module, dbg_trace_ram: a single-port-write, single-port-read DEPTH x ENTRY_W register array with a registered read.

Test Plan:
1. DEPTH=16, arm, retire 5 ops with EIP 0x1000..0x1004, stop, drain with rd_ready=1 -> 5 beats in EIP order 0x1000..0x1004, rd_last on the 5th, then state=IDLE.
2. Arm, retire 20 ops (EIP 0x2000+i), stop, drain -> count=16 and first beat EIP=0x2004.
3. trig_en=1, trig_eip=0x3007, post_cnt=2, ops 0x3000..0x300F -> FROZEN after 0x3009 and triggered=1. Last drained EIP=0x3009.
4. wb_v=1 with wb_stall=1 for 3 cycles, then 1 unstalled cycle -> exactly 1 entry captured.
5. During drain, rd_ready toggles 1,0,0,1 -> rd_data stays stable while stalled; no duplicated or lost entries.
6. RST on the 2nd drain beat -> next cycle rd_valid=0, count=0, state=IDLE.

Source files
------------

// File: rtl/dbg_trace_pkg.sv
// Shared state encoding and trace-entry layout for the retirement trace buffer.
// Define DBG_TRACE_MEMWT_EN to also record the memory-write fields in each entry.
package dbg_trace_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ARMED  = 3'd1,
    ST_POST   = 3'd2,
    ST_FROZEN = 3'd3,
    ST_DRAIN  = 3'd4
  } state_e;

  localparam int UPC_W    = 8;
  localparam int EIP_W    = 32;
  localparam int RES_W    = 64;
  localparam int TS_FLD_W = 16;

  // Memory-write fields, when present, occupy the low end of the entry.
`ifdef DBG_TRACE_MEMWT_EN
  localparam int WT_DATA_LSB = 0;
  localparam int WT_ADDR_LSB = 64;
  localparam int WT_LSB      = 96;
  localparam int RES_LSB     = 97;
`else
  localparam int RES_LSB     = 0;
`endif

  localparam int EIP_LSB = RES_LSB + RES_W;
  localparam int UPC_LSB = EIP_LSB + EIP_W;
  localparam int TS_LSB  = UPC_LSB + UPC_W;
  localparam int ENTRY_W = TS_LSB + TS_FLD_W;

endpackage

// File: rtl/dbg_trace_ram.sv
// DEPTH x W trace storage: one write port, one read port with a registered,
// reset-cleared read output that holds its value while re_i is low.
module dbg_trace_ram #(
  parameter int DEPTH = 16,
  parameter int W     = 120
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] waddr_i,
  input  logic [W-1:0]             wdata_i,
  input  logic                     re_i,
  input  logic [$clog2(DEPTH)-1:0] raddr_i,
  output logic [W-1:0]             rdata_o
);

  logic [W-1:0] mem_q [DEPTH];
  logic [W-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/dbg_trace_buffer.sv
// Retirement trace recorder: circular capture of retired micro-ops, freeze on
// EIP trigger or stop, oldest-first drain. DBG_TRACE_MEMWT_EN adds mem-write fields.
module dbg_trace_buffer
  import dbg_trace_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int TS_W  = 16
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     wb_v,
  input  logic                     wb_stall,
  input  logic [31:0]              wb_eip,
  input  logic [7:0]               wb_upc,
  input  logic [63:0]              wb_result,
  input  logic                     wb_mem_wt,
  input  logic [31:0]              wb_mem_wt_addr,
  input  logic [63:0]              wb_mem_wt_data,
  input  logic                     arm,
  input  logic                     stop,
  input  logic                     trig_en,
  input  logic [31:0]              trig_eip,
  input  logic [$clog2(DEPTH):0]   post_cnt,
  input  logic                     drain,
  output logic                     rd_valid,
  input  logic                     rd_ready,
  output logic [ENTRY_W-1:0]       rd_data,
  output logic                     rd_last,
  output logic [2:0]               state,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     triggered
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  state_e          state_q, state_d;
  logic [AW-1:0]   wptr_q, wptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [CW-1:0]   remain_q, remain_d;
  logic            trig_q, trig_d;
  logic            rd_valid_q, rd_valid_d;
  logic [TS_W-1:0] ts_q;

  logic               cap, hit, re;
  logic [AW-1:0]      raddr;
  logic [ENTRY_W-1:0] wdata;

  // Arm in the same cycle drops the capture, since the session restarts.
  assign cap = wb_v & ~wb_stall & ~arm & ((state_q == ST_ARMED) | (state_q == ST_POST));
  assign hit = cap & trig_en & (wb_eip == trig_eip) & (state_q == ST_ARMED);

  always_comb begin
    wdata = '0;
    wdata[RES_LSB +: RES_W]    = wb_result;
    wdata[EIP_LSB +: EIP_W]    = wb_eip;
    wdata[UPC_LSB +: UPC_W]    = wb_upc;
    wdata[TS_LSB +: TS_FLD_W]  = TS_FLD_W'(ts_q);
`ifdef DBG_TRACE_MEMWT_EN
    wdata[WT_LSB]              = wb_mem_wt;
    wdata[WT_ADDR_LSB +: 32]   = wb_mem_wt_addr;
    wdata[WT_DATA_LSB +: 64]   = wb_mem_wt_data;
`endif
  end

`ifndef DBG_TRACE_MEMWT_EN
  logic unused_memwt;
  assign unused_memwt = ^{wb_mem_wt, wb_mem_wt_addr, wb_mem_wt_data};
`endif

  // Drain handshake: rd_valid, once high, stays high with rd_data unchanged
  // until a cycle with rd_valid & rd_ready; that cycle completes one beat.
  always_comb begin
    state_d    = state_q;
    wptr_d     = wptr_q;
    count_d    = count_q;
    remain_d   = remain_q;
    trig_d     = trig_q;
    rd_valid_d = rd_valid_q;
    re         = 1'b0;
    raddr      = wptr_q - count_q[AW-1:0];

    if (arm && (state_q != ST_DRAIN)) begin
      state_d  = ST_ARMED;
      wptr_d   = '0;
      count_d  = '0;
      remain_d = '0;
      trig_d   = 1'b0;
    end else begin
      if (cap) begin
        wptr_d = wptr_q + 1'b1;
        if (count_q != CW'(DEPTH)) begin
          count_d = count_q + 1'b1;
        end
      end
      case (state_q)
        ST_ARMED: begin
          if (hit) begin
            trig_d = 1'b1;
          end
          if (stop) begin
            state_d = ST_FROZEN;
          end else if (hit) begin
            if (post_cnt == '0) begin
              state_d = ST_FROZEN;
            end else begin
              remain_d = post_cnt;
              state_d  = ST_POST;
            end
          end
        end
        ST_POST: begin
          if (stop) begin
            state_d = ST_FROZEN;
          end else if (cap) begin
            remain_d = remain_q - 1'b1;
            if (remain_q == CW'(1)) begin
              state_d = ST_FROZEN;
            end
          end
        end
        ST_FROZEN: begin
          if (drain && (count_q != '0)) begin
            state_d = ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (!rd_valid_q) begin
            re         = 1'b1;
            rd_valid_d = 1'b1;
          end else if (rd_ready) begin
            count_d = count_q - 1'b1;
            if (count_q == CW'(1)) begin
              rd_valid_d = 1'b0;
              state_d    = ST_IDLE;
            end else begin
              re    = 1'b1;
              raddr = wptr_q - count_q[AW-1:0] + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= ST_IDLE;
      wptr_q     <= '0;
      count_q    <= '0;
      remain_q   <= '0;
      trig_q     <= 1'b0;
      rd_valid_q <= 1'b0;
      ts_q       <= '0;
    end else begin
      state_q    <= state_d;
      wptr_q     <= wptr_d;
      count_q    <= count_d;
      remain_q   <= remain_d;
      trig_q     <= trig_d;
      rd_valid_q <= rd_valid_d;
      ts_q       <= ts_q + 1'b1;
    end
  end

  dbg_trace_ram #(
    .DEPTH (DEPTH),
    .W     (ENTRY_W)
  ) u_ram (
    .clk_i   (CLK),
    .rst_i   (RST),
    .we_i    (cap),
    .waddr_i (wptr_q),
    .wdata_i (wdata),
    .re_i    (re),
    .raddr_i (raddr),
    .rdata_o (rd_data)
  );

  assign rd_valid  = rd_valid_q;
  assign rd_last   = rd_valid_q & (count_q == CW'(1));
  assign state     = state_q;
  assign count     = count_q;
  assign triggered = trig_q;

endmodule

// File: tb/tb_dbg_trace_buffer.sv
// Bench for dbg_trace_buffer: directed scenarios plus random traffic, all
// checked against a queue-based history model of the trace buffer.
module tb_dbg_trace_buffer;
  import dbg_trace_pkg::*;

  localparam int DEPTH = 16;
  localparam int AW    = $clog2(DEPTH);

  logic               CLK, RST;
  logic               wb_v, wb_stall, wb_mem_wt;
  logic [31:0]        wb_eip, wb_mem_wt_addr, trig_eip;
  logic [7:0]         wb_upc;
  logic [63:0]        wb_result, wb_mem_wt_data;
  logic               arm, stop, trig_en, drain, rd_ready;
  logic [AW:0]        post_cnt;
  logic               rd_valid, rd_last, triggered;
  logic [ENTRY_W-1:0] rd_data;
  logic [2:0]         state;
  logic [AW:0]        count;

  dbg_trace_buffer #(.DEPTH(DEPTH), .TS_W(16)) dut (
    .CLK(CLK), .RST(RST), .wb_v(wb_v), .wb_stall(wb_stall), .wb_eip(wb_eip),
    .wb_upc(wb_upc), .wb_result(wb_result), .wb_mem_wt(wb_mem_wt),
    .wb_mem_wt_addr(wb_mem_wt_addr), .wb_mem_wt_data(wb_mem_wt_data),
    .arm(arm), .stop(stop), .trig_en(trig_en), .trig_eip(trig_eip),
    .post_cnt(post_cnt), .drain(drain), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .rd_data(rd_data), .rd_last(rd_last), .state(state), .count(count),
    .triggered(triggered)
  );

  // clock / watchdog
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // scoreboard / reference model
  logic [ENTRY_W-1:0] exp_q[$];
  state_e             m_st;
  logic               m_trig, m_rv;
  logic [15:0]        m_ts;
  int                 m_rem;
  int                 n_total, n_bad;
  logic [31:0]        got_eip[$];
  int                 nbeats, last_idx;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [ENTRY_W-1:0] mk_entry();
    logic [ENTRY_W-1:0] e;
    e = '0;
    e[RES_LSB +: 64]       = wb_result;
    e[EIP_LSB +: 32]       = wb_eip;
    e[UPC_LSB +: UPC_W]    = wb_upc;
    e[TS_LSB +: TS_FLD_W]  = m_ts;
`ifdef DBG_TRACE_MEMWT_EN
    e[WT_LSB]              = wb_mem_wt;
    e[WT_ADDR_LSB +: 32]   = wb_mem_wt_addr;
    e[WT_DATA_LSB +: 64]   = wb_mem_wt_data;
`endif
    return e;
  endfunction

  // One clock: advance the model with the inputs seen at the edge, then compare.
  task automatic step();
    logic cap, hit;
    @(posedge CLK);
    if (RST) begin
      exp_q.delete();
      m_st = ST_IDLE; m_trig = 1'b0; m_rv = 1'b0; m_ts = '0; m_rem = 0;
    end else begin
      cap = wb_v && !wb_stall && !arm && (m_st == ST_ARMED || m_st == ST_POST);
      hit = cap && trig_en && (wb_eip == trig_eip) && (m_st == ST_ARMED);
      if (cap) begin
        exp_q.push_back(mk_entry());
        if (exp_q.size() > DEPTH) void'(exp_q.pop_front());
      end
      if (arm && m_st != ST_DRAIN) begin
        exp_q.delete();
        m_st = ST_ARMED; m_trig = 1'b0;
      end else begin
        case (m_st)
          ST_ARMED: begin
            if (hit) m_trig = 1'b1;
            if (stop) m_st = ST_FROZEN;
            else if (hit) begin
              if (post_cnt == 0) m_st = ST_FROZEN;
              else begin m_rem = int'(post_cnt); m_st = ST_POST; end
            end
          end
          ST_POST: begin
            if (stop) m_st = ST_FROZEN;
            else if (cap) begin
              m_rem--;
              if (m_rem == 0) m_st = ST_FROZEN;
            end
          end
          ST_FROZEN: if (drain && exp_q.size() > 0) m_st = ST_DRAIN;
          ST_DRAIN: begin
            if (!m_rv) m_rv = 1'b1;
            else if (rd_ready) begin
              void'(exp_q.pop_front());
              if (exp_q.size() == 0) begin m_rv = 1'b0; m_st = ST_IDLE; end
            end
          end
          default: ;
        endcase
      end
      m_ts++;
    end
    #1;
    check("state", state, m_st);
    check("count", count, exp_q.size());
    check("triggered", triggered, m_trig);
    check("rd_valid", rd_valid, m_rv);
    check("rd_last", rd_last, m_rv && exp_q.size() == 1);
    if (m_rv) check("rd_data", rd_data, exp_q[0]);
  endtask

  // driver tasks
  task automatic op(input logic [31:0] eip);
    wb_v = 1'b1; wb_stall = 1'b0; wb_eip = eip;
    wb_upc = 8'($urandom); wb_result = {$urandom, $urandom};
    wb_mem_wt = 1'($urandom_range(0, 1)); wb_mem_wt_addr = $urandom;
    wb_mem_wt_data = {$urandom, $urandom};
    step();
  endtask

  task automatic idle(input int n);
    wb_v = 1'b0;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_arm();  arm = 1'b1;  step(); arm = 1'b0;  endtask
  task automatic do_stop(); stop = 1'b1; step(); stop = 1'b0; endtask

  // mode 0: always ready, 1: ready pattern 1,0,0,1, 2: random; rst_beat>0 resets on that beat
  task automatic drain_run(input int mode, input int rst_beat);
    got_eip.delete(); nbeats = 0; last_idx = 0;
    wb_v = 1'b0;
    drain = 1'b1; step(); drain = 1'b0;
    for (int i = 0; i < 400 && m_st == ST_DRAIN; i++) begin
      case (mode)
        0: rd_ready = 1'b1;
        1: rd_ready = (i % 4 == 0) || (i % 4 == 3);
        default: rd_ready = 1'($urandom_range(0, 1));
      endcase
      if (rd_valid && rd_ready) begin
        nbeats++;
        got_eip.push_back(rd_data[EIP_LSB +: 32]);
        if (rd_last) last_idx = nbeats;
        if (rst_beat != 0 && nbeats == rst_beat) begin
          RST = 1'b1; step(); RST = 1'b0;
          break;
        end
      end
      step();
    end
    rd_ready = 1'b0;
    if (m_st == ST_DRAIN) check("drain_budget", 1, 0);
  endtask

  initial begin
    n_total = 0; n_bad = 0;
    RST = 1'b1; wb_v = 0; wb_stall = 0; wb_eip = 0; wb_upc = 0; wb_result = 0;
    wb_mem_wt = 0; wb_mem_wt_addr = 0; wb_mem_wt_data = 0; arm = 0; stop = 0;
    trig_en = 0; trig_eip = 0; post_cnt = 0; drain = 0; rd_ready = 0;
    step(); step();
    RST = 1'b0;
    check("rst_state", state, 3'd0);
    check("rst_count", count, 0);
    check("rst_rd_valid", rd_valid, 0);
    check("rst_rd_data", rd_data, 0);
    idle(2);

    // 1: five ops, stop, drain in order
    do_arm();
    for (int i = 0; i < 5; i++) op(32'h1000 + i);
    idle(1); do_stop();
    drain_run(0, 0);
    check("t1_beats", nbeats, 5);
    for (int i = 0; i < 5 && i < got_eip.size(); i++) check("t1_eip", got_eip[i], 32'h1000 + i);
    check("t1_last_idx", last_idx, 5);
    check("t1_state", state, 3'd0);

    // 2: overflow keeps the newest DEPTH entries
    do_arm();
    for (int i = 0; i < 20; i++) op(32'h2000 + i);
    idle(1); do_stop();
    check("t2_count", count, DEPTH);
    drain_run(0, 0);
    check("t2_beats", nbeats, DEPTH);
    if (got_eip.size() > 0) check("t2_first_eip", got_eip[0], 32'h2004);

    // 3: trigger with post_cnt=2
    trig_en = 1'b1; trig_eip = 32'h3007; post_cnt = 2;
    do_arm();
    for (int i = 0; i < 16; i++) op(32'h3000 + i);
    idle(1);
    check("t3_state", state, 3'd3);
    check("t3_triggered", triggered, 1);
    check("t3_count", count, 10);
    trig_en = 1'b0;
    drain_run(0, 0);
    check("t3_beats", nbeats, 10);
    if (got_eip.size() > 0) check("t3_last_eip", got_eip[got_eip.size()-1], 32'h3009);

    // 4: stalled retirement is not captured
    do_arm();
    wb_v = 1'b1; wb_stall = 1'b1; wb_eip = 32'h4000;
    for (int i = 0; i < 3; i++) step();
    wb_stall = 1'b0; step();
    idle(1);
    check("t4_count", count, 1);
    do_stop();

    // 5: back-pressure during drain
    do_arm();
    for (int i = 0; i < 6; i++) op(32'h5000 + i);
    idle(1); do_stop();
    drain_run(1, 0);
    check("t5_beats", nbeats, 6);
    for (int i = 0; i < 6 && i < got_eip.size(); i++) check("t5_eip", got_eip[i], 32'h5000 + i);

    // 6: reset on the second drain beat
    do_arm();
    for (int i = 0; i < 6; i++) op(32'h6000 + i);
    idle(1); do_stop();
    drain_run(0, 2);
    check("t6_rd_valid", rd_valid, 0);
    check("t6_count", count, 0);
    check("t6_state", state, 3'd0);
    idle(2);

    // random traffic, including simultaneous arm/stop/trigger/drain
    trig_eip = 32'h7003;
    for (int i = 0; i < 3000; i++) begin
      wb_v = 1'($urandom_range(0, 3) != 0);
      wb_stall = ($urandom_range(0, 4) == 0);
      wb_eip = 32'h7000 + $urandom_range(0, 7);
      wb_upc = 8'($urandom); wb_result = {$urandom, $urandom};
      wb_mem_wt = 1'($urandom_range(0, 1)); wb_mem_wt_addr = $urandom;
      wb_mem_wt_data = {$urandom, $urandom};
      arm = ($urandom_range(0, 49) == 0);
      stop = ($urandom_range(0, 29) == 0);
      drain = ($urandom_range(0, 9) == 0);
      trig_en = ($urandom_range(0, 3) != 0);
      post_cnt = (AW+1)'($urandom_range(0, 2*DEPTH-1));
      rd_ready = 1'($urandom_range(0, 1));
      step();
    end
    arm = 0; stop = 0; drain = 0; wb_v = 0; rd_ready = 0; trig_en = 0;
    idle(2);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
